// File: rtl/tx_mac_frame_reader_pkg.sv
// Shared types and constants for the MAC-domain TX frame reader.
package tx_mac_frame_reader_pkg;

  localparam int unsigned BF      = 9;
  localparam int unsigned LEN_LSB = 0;
  localparam int unsigned LEN_MSB = 15;
  localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned KEEP_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHK,
    ST_DATA,
    ST_DRAIN,
    ST_COMMIT,
    ST_ERR
  } rd_state_e;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Byte enables for the final beat of a frame of the given length.
  function automatic logic [KEEP_W-1:0] last_keep(input logic [LEN_W-1:0] len);
    logic [2:0] r;
    r = len[2:0];
    return (r == 3'd0) ? 8'hFF : ((8'h01 << r) - 8'h01);
  endfunction

endpackage

// File: rtl/tx_rd_skid_fifo.sv
// Shift-register skid FIFO; the head entry is always slot 0 so outputs come straight from flops.
module tx_rd_skid_fifo
  import tx_mac_frame_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  beat_t            push_beat,
  input  logic             pop,
  output beat_t            head,
  output logic             head_vld,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  beat_t            ent   [DEPTH];
  beat_t            ent_n [DEPTH];
  logic             vld   [DEPTH];
  logic             vld_n [DEPTH];
  logic [CNT_W-1:0] count_n;
  logic [IDX_W-1:0] wr_idx;
  logic             pop_eff;

  always_comb begin
    pop_eff = pop & vld[0];
    for (int i = 0; i < DEPTH; i++) begin
      ent_n[i] = ent[i];
      vld_n[i] = vld[i];
    end
    if (pop_eff) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ent_n[i] = ent[i+1];
        vld_n[i] = vld[i+1];
      end
      ent_n[DEPTH-1] = '0;
      vld_n[DEPTH-1] = 1'b0;
    end
    // New beat lands just behind whatever survives this cycle's pop.
    wr_idx = IDX_W'(count - CNT_W'(pop_eff));
    if (push) begin
      ent_n[wr_idx] = push_beat;
      vld_n[wr_idx] = 1'b1;
    end
    count_n = count + CNT_W'(push) - CNT_W'(pop_eff);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
        vld[i] <= 1'b0;
      end
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= ent_n[i];
        vld[i] <= vld_n[i];
      end
      count <= count_n;
    end
  end

  assign head     = ent[0];
  assign head_vld = vld[0];

endmodule

// File: rtl/tx_mac_frame_reader.sv
// Reads committed frames out of the TX packet buffer and streams them to the MAC,
// publishing the read address once each frame is fully transmitted or dropped.
module tx_mac_frame_reader
  import tx_mac_frame_reader_pkg::*;
#(
  parameter int unsigned ADDR_W  = BF + 1,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned MAX_LEN = 9600,
  parameter int unsigned FIFO_D  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] commited_wr_addr_in,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [63:0]       rd_data,
  output logic [ADDR_W-1:0] commited_rd_addr_out,
  output logic [63:0]       m_data,
  output logic [7:0]        m_keep,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              frame_err
);

  localparam int unsigned CNT_W   = $clog2(FIFO_D + 1);
  localparam int unsigned WORDS_W = LEN_W - 2;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  rd_state_e          state, state_n;
  logic [LEN_W-1:0]   len_q;
  logic [WORDS_W-1:0] words_left;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic               issue_hdr, issue_data, frame_err_n, credit_ok;

  logic               tag_vld  [RD_LAT];
  logic               tag_hdr  [RD_LAT];
  logic               tag_last [RD_LAT];
  logic [KEEP_W-1:0]  tag_keep [RD_LAT];
  logic               hdr_arrive, data_push;
  beat_t              push_beat, fifo_head;

  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_D);
  assign hdr_arrive = tag_vld[RD_LAT-1] & tag_hdr[RD_LAT-1];
  assign data_push  = tag_vld[RD_LAT-1] & ~tag_hdr[RD_LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    issue_hdr   = 1'b0;
    issue_data  = 1'b0;
    frame_err_n = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rd_addr != commited_wr_addr_in) begin
          issue_hdr = 1'b1;
          state_n   = ST_HDR;
        end
      end
      ST_HDR: if (hdr_arrive) state_n = ST_CHK;
      ST_CHK: begin
        if ((len_q == '0) || (len_q > MAX_LEN_L)) begin
          frame_err_n = 1'b1;
          state_n     = ST_ERR;
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (credit_ok) begin
          issue_data = 1'b1;
          if (words_left == WORDS_W'(1)) state_n = ST_DRAIN;
        end
      end
      ST_DRAIN:  if (m_valid & m_ready & m_last) state_n = ST_COMMIT;
      ST_COMMIT: state_n = ST_IDLE;
      ST_ERR:    state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Address, length, word and in-flight bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr              <= '0;
      commited_rd_addr_out <= '0;
      len_q                <= '0;
      words_left           <= '0;
      inflight             <= '0;
      frame_err            <= 1'b0;
    end else begin
      frame_err <= frame_err_n;
      inflight  <= inflight + CNT_W'(issue_data) - CNT_W'(data_push);
      if (issue_hdr | issue_data) rd_addr <= rd_addr + ADDR_W'(1);
      if (hdr_arrive) len_q <= rd_data[LEN_MSB:LEN_LSB];
      if (state == ST_CHK) words_left <= WORDS_W'(({1'b0, len_q} + (LEN_W + 1)'(7)) >> 3);
      if (issue_data) words_left <= words_left - WORDS_W'(1);
      if (state == ST_COMMIT) commited_rd_addr_out <= rd_addr;
      // A bad header means the rest of the committed data cannot be parsed; skip all of it.
      if (state == ST_ERR) begin
        rd_addr              <= commited_wr_addr_in;
        commited_rd_addr_out <= commited_wr_addr_in;
      end
    end
  end

  // Tags travel alongside the BRAM read so they line up with rd_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld[i]  <= 1'b0;
        tag_hdr[i]  <= 1'b0;
        tag_last[i] <= 1'b0;
        tag_keep[i] <= '0;
      end
    end else begin
      tag_vld[0]  <= issue_hdr | issue_data;
      tag_hdr[0]  <= issue_hdr;
      tag_last[0] <= issue_data & (words_left == WORDS_W'(1));
      tag_keep[0] <= (issue_data & (words_left == WORDS_W'(1))) ? last_keep(len_q) : 8'hFF;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_hdr[i]  <= tag_hdr[i-1];
        tag_last[i] <= tag_last[i-1];
        tag_keep[i] <= tag_keep[i-1];
      end
    end
  end

  always_comb begin
    push_beat.last = tag_last[RD_LAT-1];
    push_beat.keep = tag_keep[RD_LAT-1];
    push_beat.data = rd_data;
  end

  tx_rd_skid_fifo #(
    .DEPTH (FIFO_D),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (data_push),
    .push_beat (push_beat),
    .pop       (m_ready),
    .head      (fifo_head),
    .head_vld  (m_valid),
    .count     (fifo_count)
  );

  assign m_data = fifo_head.data;
  assign m_keep = fifo_head.keep;
  assign m_last = fifo_head.last;

endmodule

// File: tb/tb_tx_mac_frame_reader.sv
// Directed bench for tx_mac_frame_reader with a 2-cycle-latency BRAM model.
module tb_tx_mac_frame_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  commited_wr_addr_in;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [9:0]  commited_rd_addr_out;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_valid, m_last, m_ready, frame_err;

  logic [63:0] mem [1024];
  logic [63:0] pipe0, pipe1;
  int checks = 0;
  int errors = 0;
  int fifo_max = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe0 <= mem[rd_addr];
    pipe1 <= pipe0;
  end
  assign rd_data = pipe1;

  tx_mac_frame_reader dut (
    .clk                  (clk),
    .reset                (reset),
    .commited_wr_addr_in  (commited_wr_addr_in),
    .rd_addr              (rd_addr),
    .rd_data              (rd_data),
    .commited_rd_addr_out (commited_rd_addr_out),
    .m_data               (m_data),
    .m_keep               (m_keep),
    .m_valid              (m_valid),
    .m_last               (m_last),
    .m_ready              (m_ready),
    .frame_err            (frame_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept beats until stop_at have been taken; first = address of first data word.
  task automatic collect(input int nb, input int first, input logic [7:0] lk,
                         input bit alt, input int stop_at);
    int got = 0;
    int cyc = 0;
    int idx;
    while (got < stop_at && cyc < 400) begin
      @(negedge clk);
      cyc++;
      m_ready = alt ? ((cyc % 2) == 1) : 1'b1;
      if (int'(dut.u_fifo.count) > fifo_max) fifo_max = int'(dut.u_fifo.count);
      if (m_valid && m_ready) begin
        idx = (first + got) % 1024;
        check("beat_data", m_data, mem[idx]);
        check("beat_keep", 64'(m_keep), 64'((got == nb - 1) ? lk : 8'hFF));
        check("beat_last", 64'(m_last), 64'(got == nb - 1));
        got++;
      end
    end
    check("beat_count", 64'(got), 64'(stop_at));
  endtask

  task automatic wait_commit(input logic [9:0] exp);
    int cyc = 0;
    while (commited_rd_addr_out !== exp && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("commit_out", 64'(commited_rd_addr_out), 64'(exp));
  endtask

  task automatic expect_err(input logic [9:0] exp);
    int cyc = 0;
    bit seen = 0;
    bit saw_v = 0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (m_valid) saw_v = 1;
      if (frame_err) seen = 1;
    end
    check("err_pulse", 64'(seen), 64'd1);
    @(negedge clk);
    check("err_one_clk", 64'(frame_err), 64'd0);
    check("err_rd_addr", 64'(rd_addr), 64'(exp));
    check("err_commit", 64'(commited_rd_addr_out), 64'(exp));
    check("err_no_valid", 64'(saw_v | m_valid), 64'd0);
  endtask

  task automatic check_all_zero();
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_commit", 64'(commited_rd_addr_out), 64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_keep", 64'(m_keep), 64'd0);
    check("rst_data", m_data, 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = {16'hDA7A, 16'(a), 32'(a) * 32'h9E3779B1};
    reset = 1'b1;
    m_ready = 1'b1;
    commited_wr_addr_in = '0;
    repeat (3) @(negedge clk);
    check_all_zero();

    // Frame A: L=60 at word 0, data words 1..8; reset after beat 3
    mem[0] = {48'hFFFF_0000_BEEF, 16'd60};
    commited_wr_addr_in = 10'd9;
    reset = 1'b0;
    collect(8, 1, 8'h0F, 1'b0, 3);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_all_zero();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Re-read from 0 after reset
    collect(8, 1, 8'h0F, 1'b0, 8);
    wait_commit(10'd9);
    check("a_rd_addr", 64'(rd_addr), 64'd9);

    // Same frame under backpressure 1,0,1,0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fifo_max = 0;
    collect(8, 1, 8'h0F, 1'b1, 8);
    m_ready = 1'b1;
    wait_commit(10'd9);
    check("fifo_bound", 64'(fifo_max <= 4), 64'd1);

    // Bad lengths: L=0 at 9, then L=9601 at 20
    mem[9] = {48'h1234_5678_9ABC, 16'd0};
    commited_wr_addr_in = 10'd20;
    expect_err(10'd20);
    mem[20] = {48'h0, 16'd9601};
    commited_wr_addr_in = 10'd1022;
    expect_err(10'd1022);

    // Wrap: header at 1022, L=24, data at 1023, 0, 1
    mem[1022] = {48'hAAAA_BBBB_CCCC, 16'd24};
    mem[0]    = 64'h0123_4567_89AB_CDEF;
    mem[1]    = 64'hFEDC_BA98_7654_3210;
    commited_wr_addr_in = 10'd2;
    collect(3, 1023, 8'hFF, 1'b0, 3);
    wait_commit(10'd2);

    // Two frames committed at once: L=16 at 0, L=9 at 3
    reset = 1'b1;
    mem[0] = {48'h0, 16'd16};
    mem[1] = 64'h1111_1111_1111_1111;
    mem[2] = 64'h2222_2222_2222_2222;
    mem[3] = {48'h0, 16'd9};
    mem[4] = 64'h4444_4444_4444_4444;
    mem[5] = 64'h5555_5555_5555_5555;
    commited_wr_addr_in = 10'd6;
    @(negedge clk);
    reset = 1'b0;
    collect(2, 1, 8'hFF, 1'b0, 2);
    wait_commit(10'd3);
    collect(2, 4, 8'h01, 1'b0, 2);
    wait_commit(10'd6);
    check("end_rd_addr", 64'(rd_addr), 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
